mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store engine; consumes EX/MEM register outputs (mem_op, mem_result, mem_busB_mux2,
//  mem_memwr, mem_memtoreg) and runs one data-memory transaction per instruction over a req/ack bus.
//  Performs little-endian byte/halfword lane steering, sign/zero extension and alignment checks.
//  Stalls the pipeline until the access completes; returns aligned load data to the MEM/WB register.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles waiting for dm_ack before bus_err; 8-bit counter, legal 1..255
// PORTS
//  clk            in   1   pipeline clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  mem_op         in   6   opcode: LB 20h LH 21h LW 23h LBU 24h LHU 25h SB 28h SH 29h SW 2Bh
//  mem_memwr      in   1   store instruction in MEM
//  mem_memtoreg   in   2   2'd1 = load instruction in MEM
//  mem_result     in   32  effective address
//  mem_busB_mux2  in   32  store data (rt)
//  adv            in   1   pipeline advances MEM->WB this cycle
//  flush          in   1   squash MEM instruction (exception/branch)
//  dm_req         out  1   memory request
//  dm_we          out  1   write request
//  dm_addr        out  32  word address {addr[31:2],2'b00}
//  dm_be          out  4   byte enables
//  dm_wdata       out  32  lane-replicated store data
//  dm_rdata       in   32  read data, valid with dm_ack
//  dm_ack         in   1   transaction complete
//  stall          out  1   freeze IF..MEM
//  load_data      out  32  extended load result
//  load_valid     out  1   load_data valid
//  adel / ades    out  1   load / store address error pulse
//  bad_vaddr      out  32  faulting address
//  bus_err        out  1   timeout pulse
// BEHAVIOUR
//  access = (mem_memtoreg==1 | mem_memwr) & ~flush. Reset: all outputs 0, state IDLE, counter 0.
//  States IDLE, REQ, DONE.
//  IDLE: access & misaligned (LH/LHU/SH addr[0]; LW/SW addr[1:0]!=0) -> adel/ades=1, bad_vaddr=addr
//   one cycle, no dm_req, stall=0, go DONE. access & aligned -> dm_req=1 combinationally; dm_ack same
//   cycle -> capture, DONE; else REQ. Unknown opcode with access -> treated as no access.
//  REQ: dm_req held, addr/be/wdata/we stable; counter++; dm_ack -> DONE; counter==TIMEOUT_CYC ->
//   bus_err pulse, load_data=0, DONE.
//  DONE: stall=0, load_valid=1 for loads; hold until adv, then IDLE (same instruction never reissued).
//  stall = access & state!=DONE. Zero-wait memory therefore costs exactly 1 stall cycle.
//  Byte enables: SB 4'b0001<<addr[1:0]; SH addr[1]?4'b1100:4'b0011; SW 4'b1111; loads 4'b1111.
//  dm_wdata: SB {4{rt[7:0]}}, SH {2{rt[15:0]}}, SW rt.
//  Load extract: byte lane addr[1:0]; half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  flush in IDLE: nothing issued. flush in REQ: dm_req kept until dm_ack (no abandoned bus cycle),
//   data discarded, load_valid=0, return IDLE; stall stays 0 once flush seen.
//  Reset mid-REQ: dm_req drops immediately; bus side must tolerate.
// STRUCTURE
//  Shared package: opcode constants, state enum, MEMTOREG_LOAD=2'd1.
//  Sub-module load_align (combinational lane extract + extension), instanced once.
// TESTING
//  LW 0x100, memory returns 0xDEADBEEF with ack same cycle -> stall 1 cycle, load_data=DEADBEEF.
//  LB addr 0x103, rdata 0x80xxxxxx -> be=1111, load_data=FFFFFF80; LBU -> 00000080.
//  SH addr 0x202, rt=0x1234ABCD -> dm_we=1, be=1100, wdata=ABCDABCD, dm_addr=0x200.
//  LW addr 0x101 -> adel=1, bad_vaddr=0x101, dm_req never asserted, stall=0.
//  Ack delayed 3 cycles -> stall 4 cycles, dm_addr/be stable; no ack, TIMEOUT_CYC=4 -> bus_err after 4.
//  flush asserted in REQ -> req held to ack, load_valid=0; rst_n low mid-REQ -> dm_req=0 immediately.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, FSM state type and lane helpers for the MEM-stage load/store engine.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] MEMTOREG_LOAD = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return |addr_lo;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [5:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_SB:   return 4'b0001 << addr_lo;
      OP_SH:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rt);
    case (op)
      OP_SB:   return {4{rt[7:0]}};
      OP_SH:   return {2{rt[15:0]}};
      OP_SW:   return rt;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load-side lane extraction and sign/zero extension of a little-endian read word.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data = {24'h0, byte_v};
      OP_LH:   data = {{16{half_v[15]}}, half_v};
      OP_LHU:  data = {16'h0, half_v};
      OP_LW:   data = rdata;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack data-memory transaction per instruction,
// stalling the pipeline until it completes.
//
//  state | meaning
//  IDLE  | no bus cycle open; new access issued combinationally from MEM inputs
//  REQ   | bus cycle open, request fields held from registers, timeout running
//  DONE  | access finished, result presented until the pipeline advances
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  mem_op,
  input  logic        mem_memwr,
  input  logic [1:0]  mem_memtoreg,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_busB_mux2,
  input  logic        adv,
  input  logic        flush,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr,
  output logic        bus_err
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYC);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        flushed_q;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;

  logic        is_load, is_store, access, mis, issue, flush_seen;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [8:0]  cnt_next;
  logic [5:0]  align_op;
  logic [1:0]  align_lo;
  logic [31:0] align_data;

  // Gating with rst_n keeps the combinational request low while reset is held.
  assign is_load    = op_is_load(mem_op) && (mem_memtoreg == MEMTOREG_LOAD);
  assign is_store   = op_is_store(mem_op) && mem_memwr;
  assign access     = rst_n && !flush && (is_load || is_store);
  assign mis        = misaligned(mem_op, mem_result[1:0]);
  assign issue      = (state_q == ST_IDLE) && access && !mis;
  assign flush_seen = flushed_q || flush;
  assign be_c       = byte_en(mem_op, mem_result[1:0]);
  assign wdata_c    = store_data(mem_op, mem_busB_mux2);
  assign cnt_next   = {1'b0, cnt_q} + 9'd1;

  assign align_op = (state_q == ST_REQ) ? op_q : mem_op;
  assign align_lo = (state_q == ST_REQ) ? addr_q[1:0] : mem_result[1:0];

  mem_access_unit_load_align u_load_align (
    .op      (align_op),
    .addr_lo (align_lo),
    .rdata   (dm_rdata),
    .data    (align_data)
  );

  always_comb begin
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 32'h0;
    dm_be    = 4'h0;
    dm_wdata = 32'h0;
    if (issue) begin
      dm_req   = 1'b1;
      dm_we    = is_store;
      dm_addr  = {mem_result[31:2], 2'b00};
      dm_be    = be_c;
      dm_wdata = wdata_c;
    end else if (state_q == ST_REQ) begin
      dm_req   = 1'b1;
      dm_we    = we_q;
      dm_addr  = {addr_q[31:2], 2'b00};
      dm_be    = be_q;
      dm_wdata = wdata_q;
    end
  end

  // A squashed instruction must not hold the pipeline even while its bus cycle drains.
  assign stall = access && (((state_q == ST_IDLE) && !mis) ||
                            ((state_q == ST_REQ) && !flushed_q));

  assign adel      = (state_q == ST_IDLE) && access && mis && is_load;
  assign ades      = (state_q == ST_IDLE) && access && mis && is_store;
  assign bad_vaddr = (adel || ades) ? mem_result : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'h0;
      flushed_q  <= 1'b0;
      op_q       <= 6'h0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q      <= 8'h0;
          flushed_q  <= 1'b0;
          load_valid <= 1'b0;
          load_data  <= 32'h0;
          if (access && mis) begin
            state_q <= ST_DONE;
          end else if (issue) begin
            op_q    <= mem_op;
            addr_q  <= mem_result;
            be_q    <= be_c;
            wdata_q <= wdata_c;
            we_q    <= is_store;
            if (dm_ack) begin
              state_q    <= ST_DONE;
              load_valid <= is_load;
              load_data  <= align_data;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (flush) flushed_q <= 1'b1;
          if (dm_ack) begin
            if (flush_seen) begin
              state_q <= ST_IDLE;
            end else begin
              state_q    <= ST_DONE;
              load_valid <= !we_q;
              load_data  <= align_data;
            end
          end else if (cnt_next == TIMEOUT_LIM) begin
            // Timeout of a squashed access is not reported: the instruction no longer exists.
            if (flush_seen) begin
              state_q <= ST_IDLE;
            end else begin
              state_q    <= ST_DONE;
              bus_err    <= 1'b1;
              load_valid <= !we_q;
              load_data  <= 32'h0;
            end
          end else begin
            cnt_q <= cnt_next[7:0];
          end
        end
        ST_DONE: begin
          if (adv || flush) begin
            state_q    <= ST_IDLE;
            load_valid <= 1'b0;
            load_data  <= 32'h0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
